// File: rtl/poc_pkg.sv
// Shared constants and types for the parallel output controller.
// Used by poc_core and poc_printer_if. The optional completion timeout is
// enabled with the POC_TIMEOUT_EN macro (see poc_printer_if).
package poc_pkg;

    // Register-bus address map
    localparam logic [2:0] SR0_ADDR  = 3'd0;  // mode: 1 = interrupt, 0 = polling
    localparam logic [2:0] DATA_ADDR = 3'd1;  // data buffer BR
    localparam logic [2:0] ERR_ADDR  = 3'd6;  // sticky timeout error
    localparam logic [2:0] SR7_ADDR  = 3'd7;  // ready for next byte

    // SR7 = 1 (ready), SR0 = 0 (polling)
    localparam logic [7:0] SR_RESET = 8'b1000_0000;

    // Printer handshake FSM encoding
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStrobe   = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } poc_state_e;

endpackage

// File: rtl/poc_printer_if.sv
// Printer strobe/ready handshake for the parallel output controller.
// Latches the byte at strobe start, drives tr for TR_PULSE_CYCLES, then waits
// for the printer to go busy and return to idle before reporting done.
// With POC_TIMEOUT_EN defined, a wait longer than TIMEOUT_CYCLES aborts the
// transfer and reports done together with err.
module poc_printer_if
    import poc_pkg::*;
#(
    parameter int unsigned TR_PULSE_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       rdy_i,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] pd_o,
    output logic       tr_o
);

    if (TR_PULSE_CYCLES < 1 || TR_PULSE_CYCLES > 15) begin : g_bad_pulse
        $error("TR_PULSE_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    poc_state_e state_q, state_d;
    logic [3:0] strobe_cnt_q, strobe_cnt_d;
    logic [7:0] pd_q, pd_d;
    logic       tr_q, tr_d;
    logic       timeout_hit;

`ifdef POC_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;

    assign timeout_hit = (state_q == StWaitBusy || state_q == StWaitDone) &&
                         (to_cnt_q == TimeoutW'(TIMEOUT_CYCLES - 1));

    // Timeout counter: cleared while strobing, counts while waiting on the printer
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == StStrobe) begin
            to_cnt_d = '0;
        end else if (state_q == StWaitBusy || state_q == StWaitDone) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            strobe_cnt_q <= 4'd0;
            pd_q         <= 8'd0;
            tr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            strobe_cnt_q <= strobe_cnt_d;
            pd_q         <= pd_d;
            tr_q         <= tr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && rdy_i) state_d = StStrobe;
            end
            StStrobe: begin
                if (strobe_cnt_q >= 4'(TR_PULSE_CYCLES)) state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (timeout_hit)  state_d = StIdle;
                else if (!rdy_i)  state_d = StWaitDone;
            end
            StWaitDone: begin
                if (rdy_i || timeout_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        strobe_cnt_d = strobe_cnt_q;
        pd_d         = pd_q;
        tr_d         = tr_q;
        done_o       = 1'b0;
        err_o        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && rdy_i) begin
                    pd_d         = byte_i;
                    tr_d         = 1'b1;
                    strobe_cnt_d = 4'd1;
                end
            end
            StStrobe: begin
                if (strobe_cnt_q >= 4'(TR_PULSE_CYCLES)) begin
                    tr_d = 1'b0;
                end else begin
                    strobe_cnt_d = strobe_cnt_q + 4'd1;
                end
            end
            StWaitBusy: begin
                if (timeout_hit) begin
                    tr_d   = 1'b0;
                    done_o = 1'b1;
                    err_o  = 1'b1;
                end
            end
            StWaitDone: begin
                // A printer completing on the limit cycle is a normal finish
                if (rdy_i) begin
                    done_o = 1'b1;
                end else if (timeout_hit) begin
                    tr_d   = 1'b0;
                    done_o = 1'b1;
                    err_o  = 1'b1;
                end
            end
            default: begin
                tr_d = 1'b0;
            end
        endcase
    end

    assign pd_o = pd_q;
    assign tr_o = tr_q;

endmodule

// File: rtl/poc_core.sv
// Parallel output controller: register-bus responder holding SR and BR,
// the registered read path and the active-low interrupt. The printer
// handshake lives in poc_printer_if; its optional timeout is enabled with
// the POC_TIMEOUT_EN macro.
module poc_core
    import poc_pkg::*;
#(
    parameter int unsigned TR_PULSE_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic       reg_in,
    input  logic [7:0] data_in,
    output logic       reg_out,
    output logic       irq,
    output logic [7:0] pd,
    output logic       tr,
    input  logic       rdy
);

    logic [7:0] sr_q, sr_d;
    logic [7:0] br_q, br_d;
    logic       reg_out_q, reg_out_d;
    logic       irq_q, irq_d;
    logic       done;
    logic       err;

    poc_printer_if #(
        .TR_PULSE_CYCLES(TR_PULSE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_printer_if (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(~sr_q[SR7_ADDR]),
        .byte_i (br_q),
        .rdy_i  (rdy),
        .done_o (done),
        .err_o  (err),
        .pd_o   (pd),
        .tr_o   (tr)
    );

    // Register updates: printer done first so a same-cycle processor write to
    // SR7 overrides it; a timeout error then forces the sticky SR6 bit.
    always_comb begin
        sr_d = sr_q;
        br_d = br_q;
        if (done) sr_d[SR7_ADDR] = 1'b1;
        if (rw) begin
            if (addr == DATA_ADDR) begin
                br_d = data_in;
            end else begin
                sr_d[addr] = reg_in;
            end
        end
        if (err) sr_d[ERR_ADDR] = 1'b1;
    end

    // Read path and interrupt, both one cycle behind the register state
    always_comb begin
        reg_out_d = reg_out_q;
        if (!rw) begin
            reg_out_d = (addr == DATA_ADDR) ? 1'b0 : sr_q[addr];
        end
        irq_d = ~(sr_q[SR0_ADDR] & sr_q[SR7_ADDR]);
    end

    // Bus-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= SR_RESET;
            br_q      <= 8'd0;
            reg_out_q <= 1'b0;
            irq_q     <= 1'b1;
        end else begin
            sr_q      <= sr_d;
            br_q      <= br_d;
            reg_out_q <= reg_out_d;
            irq_q     <= irq_d;
        end
    end

    assign reg_out = reg_out_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_poc_core.sv
// Self-checking bench for poc_core. Expected read bits and printed bytes are
// queued when the stimulus is driven and compared when the DUT produces them.
// The timeout scenario runs only when POC_TIMEOUT_EN is defined.
module tb_poc_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rw;
    logic [2:0] addr;
    logic       reg_in;
    logic [7:0] data_in;
    logic       reg_out;
    logic       irq;
    logic [7:0] pd;
    logic       tr;
    logic       rdy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pd_sb[$];
    logic       rd_sb[$];
    logic       any_tr;

    poc_core #(
        .TR_PULSE_CYCLES(1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rw     (rw),
        .addr   (addr),
        .reg_in (reg_in),
        .data_in(data_in),
        .reg_out(reg_out),
        .irq    (irq),
        .pd     (pd),
        .tr     (tr),
        .rdy    (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic b, input logic [7:0] d);
        rw      = 1'b1;
        addr    = a;
        reg_in  = b;
        data_in = d;
        cycle();
        rw      = 1'b0;
        addr    = 3'd0;
        reg_in  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic exp, input string tag);
        rw   = 1'b0;
        addr = a;
        rd_sb.push_back(exp);
        cycle();
        check(tag, reg_out, (rd_sb.size() > 0) ? rd_sb.pop_front() : 1'bx);
    endtask

    function automatic logic [7:0] pop_pd();
        return (pd_sb.size() > 0) ? pd_sb.pop_front() : 8'hxx;
    endfunction

    // Printer model: wait for the strobe, check the byte and pulse width, go busy
    // drop_after cycles after tr rose, stay busy busy_len cycles, then go idle.
    task automatic serve(input int drop_after, input int busy_len, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tr === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cycle();
        end
        check({tag, "_tr_seen"}, seen, 1);
        if (!seen) return;
        check({tag, "_pd"}, pd, pop_pd());
        cycle();
        check({tag, "_tr_width"}, tr, 0);
        repeat (drop_after - 1) cycle();
        rdy = 1'b0;
        repeat (busy_len) cycle();
        rdy = 1'b1;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        rw      = 1'b0;
        addr    = 3'd0;
        reg_in  = 1'b0;
        data_in = 8'd0;
        rdy     = 1'b1;
        repeat (2) cycle();
        check("reset_irq", irq, 1);
        check("reset_tr", tr, 0);
        check("reset_pd", pd, 0);
        check("reset_reg_out", reg_out, 0);
        rst_n = 1'b1;
        cycle();
        rd(3'd7, 1'b1, "rst_sr7");
        rd(3'd0, 1'b0, "rst_sr0");
        rd(3'd1, 1'b0, "rd_br_zero");

        // Polling transfer
        wr(3'd1, 1'b0, 8'h48);
        wr(3'd7, 1'b0, 8'h00);
        pd_sb.push_back(8'h48);
        check("poll_tr_lat0", tr, 0);
        cycle();
        check("poll_tr_lat1", tr, 1);
        serve(2, 5, "poll");
        rd(3'd7, 1'b1, "poll_sr7_done");
        check("poll_irq", irq, 1);

        // Interrupt mode
        wr(3'd0, 1'b1, 8'h00);
        check("irq_lag", irq, 1);
        cycle();
        check("irq_assert", irq, 0);
        wr(3'd1, 1'b0, 8'h69);
        wr(3'd7, 1'b0, 8'h00);
        pd_sb.push_back(8'h69);
        check("irq_hold", irq, 0);
        cycle();
        check("irq_clear", irq, 1);
        serve(2, 3, "intr");
        cycle();
        check("irq_reassert", irq, 0);
        wr(3'd0, 1'b0, 8'h00);
        cycle();
        check("irq_poll_mode", irq, 1);

        // Busy printer; BR untouched so the old byte prints again
        rdy = 1'b0;
        wr(3'd7, 1'b0, 8'h00);
        pd_sb.push_back(8'h69);
        any_tr = 1'b0;
        repeat (20) begin
            cycle();
            if (tr !== 1'b0) any_tr = 1'b1;
        end
        check("busy_no_tr", any_tr, 0);
        rd(3'd7, 1'b0, "busy_sr7_pending");
        rdy = 1'b1;
        cycle();
        check("busy_release_tr", tr, 1);
        serve(2, 3, "busy");

        // BR write mid-transfer, then SR7 write colliding with completion
        wr(3'd1, 1'b0, 8'h55);
        wr(3'd7, 1'b0, 8'h00);
        pd_sb.push_back(8'h55);
        cycle();
        check("col_tr", tr, 1);
        check("col_pd", pd, pop_pd());
        cycle();
        rdy = 1'b0;
        wr(3'd1, 1'b0, 8'hAA);
        check("col_pd_hold", pd, 8'h55);
        cycle();
        rdy = 1'b1;
        wr(3'd7, 1'b0, 8'h00);
        pd_sb.push_back(8'hAA);
        rd(3'd7, 1'b0, "col_sr7_kept");
        serve(2, 3, "col");
        rd(3'd7, 1'b1, "col_sr7_done");

`ifdef POC_TIMEOUT_EN
        // Printer never goes busy: transfer aborts with the sticky error
        wr(3'd7, 1'b0, 8'h00);
        pd_sb.push_back(8'hAA);
        cycle();
        check("to_tr", tr, 1);
        check("to_pd", pd, pop_pd());
        repeat (17) cycle();
        rd(3'd7, 1'b1, "to_sr7");
        rd(3'd6, 1'b1, "to_sr6");
        check("to_tr_low", tr, 0);
        rd(3'd6, 1'b1, "to_sr6_sticky");
        wr(3'd6, 1'b0, 8'h00);
        rd(3'd6, 1'b0, "to_sr6_clr");
`else
        // SR6 is plain storage
        wr(3'd6, 1'b1, 8'h00);
        rd(3'd6, 1'b1, "sr6_store1");
        wr(3'd6, 1'b0, 8'h00);
        rd(3'd6, 1'b0, "sr6_store0");
`endif

        // Reset in the middle of a transfer
        wr(3'd1, 1'b0, 8'h3C);
        wr(3'd7, 1'b0, 8'h00);
        pd_sb.push_back(8'h3C);
        cycle();
        check("mid_tr", tr, 1);
        check("mid_pd", pd, pop_pd());
        cycle();
        rdy = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_tr", tr, 0);
        check("mid_rst_pd", pd, 0);
        check("mid_rst_irq", irq, 1);
        rdy = 1'b1;
        cycle();
        rst_n = 1'b1;
        cycle();
        rd(3'd7, 1'b1, "mid_rst_sr7");
        check("mid_rst_no_resend", tr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/poc_core.md
Name: poc_core

Overview:
- Parallel Output Controller: the responder end of the processor's bit-serial register bus (rw/addr/reg_in/reg_out/irq) plus an 8-bit data port.
- Holds the mode/status register SR and the data buffer BR.
- Forwards each buffered byte to a printer over a strobe/ready handshake.
- Signals "ready for next byte" by status polling (SR7) or by an active-low interrupt (irq), selected by SR0.

Parameters:
- TR_PULSE_CYCLES, 1, width of the tr strobe in clk cycles (legal range 1..15).
- TIMEOUT_CYCLES, 1024, printer completion timeout in cycles; used only when POC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rw  in  1  access type: 1 = write, 0 = read.
- addr  in  3  register select: 0 = SR0 mode, 1 = BR data, 7 = SR7 ready, others = SR[addr].
- reg_in  in  1  write bit for SR[addr].
- data_in  in  8  byte written to BR when rw=1 and addr=1.
- reg_out  out  1  registered read bit.
- irq  out  1  interrupt request, active low.
- pd  out  8  printer data.
- tr  out  1  printer strobe, active high.
- rdy  in  1  printer ready: 1 = idle, 0 = busy.

Behaviour:
- Reset (async, rst_n=0):
  - SR=8'b1000_0000 (SR7=1 ready, SR0=0 polling), BR=0.
  - pd=0, tr=0, reg_out=0, irq=1, FSM=IDLE, strobe/timeout counters=0.
- Reset asserted mid-transfer aborts immediately to these values; no byte is resent.

Register writes (rw=1), applied at the clock edge:
- addr=1 loads BR<=data_in; SR is unchanged.
- Any other addr sets SR[addr]<=reg_in.
- A BR write during a transfer does not disturb pd; pd is captured at strobe start.

Register reads (rw=0):
- reg_out<=SR[addr] on the next edge (1-cycle latency).
- addr=1 reads 0.
- reg_out holds its value while rw=1.

irq:
- Registered: irq<=~(SR0 & SR7), evaluated on the post-update SR value, so it changes one cycle after SR changes.
- Always 1 in polling mode.

FSM (states IDLE, STROBE, WAIT_BUSY, WAIT_DONE):
- IDLE: if SR7==0 and rdy==1 -> pd<=BR, tr<=1, counter<=1, go STROBE. If SR7==0 and rdy==0 -> stay.
- STROBE: hold tr=1 for TR_PULSE_CYCLES total cycles, then tr<=0, go WAIT_BUSY.
- WAIT_BUSY: wait for rdy==0, then go WAIT_DONE. If rdy is already 0 on entry, advance next cycle.
- WAIT_DONE: wait for rdy==1, then SR7<=1 and go IDLE.

Latency:
- With an immediately responsive printer, tr rises 1 cycle after SR7 is cleared.
- SR7 returns to 1 on the edge after rdy rises in WAIT_DONE.

Collision rules:
- Processor write to SR7 in the same cycle as the FSM setting SR7 -> the processor write wins.
- Processor writing SR7=1 mid-transfer sets the flag, but the FSM completes the transfer and ends in IDLE.
- SR7=0 with no new BR write re-prints the old BR contents (legal).

Optional Feature:
POC_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: tr=0, SR7<=1, SR6<=1 (sticky error, cleared only by a processor write of 0), go IDLE.
  - The counter clears on entry to STROBE.
- Undefined: no counter; the FSM waits indefinitely and SR6 is a plain storage bit.

Decomposition:
- Shared package poc_pkg holds:
  - address constants SR0_ADDR=0, DATA_ADDR=1, ERR_ADDR=6, SR7_ADDR=7;
  - the FSM state encoding (2 bits);
  - the SR reset value.
- One natural sub-module, poc_printer_if: the strobe/handshake FSM plus the timeout logic, with interface start, byte, done, and err.
- The top level keeps SR, BR, the read path and irq.

Test Plan:
- Reset -> SR7 read gives reg_out=1 and SR0 read gives 0 (each 1 cycle after the read); irq=1, tr=0, pd=0.
- Polling: write BR=8'h48, write SR7=0; printer drops rdy 2 cycles after tr and raises it 5 cycles later -> pd=8'h48, tr high 1 cycle, SR7 reads 1 after rdy rises, irq stays 1.
- Interrupt: write SR0=1 -> irq=0 within 2 cycles. Write BR=8'h69, SR7=0 -> irq=1 the cycle after SR7 clears; irq=0 again after printer completion.
- Printer busy: hold rdy=0, write SR7=0 -> no tr for 20 cycles. Release rdy -> tr the next cycle.
- Collision: processor writes SR7=0 on the same edge the FSM completes -> SR7 ends 0 and a new transfer starts. Write BR=8'hAA mid-transfer -> pd stays at the old byte.
- POC_TIMEOUT_EN, TIMEOUT_CYCLES=16, rdy stuck at 1 after strobe -> after 16 cycles SR7=1 and SR6=1. Writing SR6=0 clears it.
